// File: rtl/counter_seq_checker.sv
// Watches a counter's output every cycle and flags any sample that does not
// hold INIT_VAL while idle or does not step by exactly one while enabled.
module counter_seq_checker #(
  parameter int unsigned      WIDTH       = 4,
  parameter logic [WIDTH-1:0] INIT_VAL    = {WIDTH{1'b1}},
  parameter bit               DIR         = 1'b1,
  parameter bit               RESYNC      = 1'b0,
  parameter bit               STOP_ON_ERR = 1'b0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] cnt_in,
  output logic             err,
  output logic             err_sticky,
  output logic [7:0]       err_count,
  output logic [7:0]       wrap_count,
  output logic             locked,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StArm   = 2'b01,
    StTrack = 2'b10,
    StHalt  = 2'b11
  } state_e;

  // Adding all-ones is a decrement modulo 2^WIDTH.
  localparam logic [WIDTH-1:0] Step    = DIR ? {WIDTH{1'b1}} : WIDTH'(1);
  localparam logic [WIDTH-1:0] WrapVal = DIR ? {WIDTH{1'b0}} : {WIDTH{1'b1}};

  state_e           state_q, state_d;
  logic [WIDTH-1:0] exp_q, exp_d;
  logic             err_q, err_d;
  logic             sticky_q, sticky_d;
  logic [7:0]       err_cnt_q, err_cnt_d;
  logic [7:0]       wrap_cnt_q, wrap_cnt_d;
  logic             mismatch;
  logic             wrap;

  always_comb begin
    state_d    = state_q;
    exp_d      = exp_q;
    err_d      = 1'b0;
    sticky_d   = sticky_q;
    err_cnt_d  = err_cnt_q;
    wrap_cnt_d = wrap_cnt_q;
    mismatch   = 1'b0;
    wrap       = 1'b0;

    case (state_q)
      StIdle: begin
        if (en) begin
          state_d = StArm;
        end else begin
          mismatch = (cnt_in !== INIT_VAL);
        end
      end
      StArm: begin
        // First enabled sample is ambiguous; anchor on the one after it.
        exp_d   = cnt_in + Step;
        state_d = en ? StTrack : StIdle;
      end
      StTrack: begin
        if (en) begin
          mismatch = (cnt_in !== exp_q);
          wrap     = !mismatch && (cnt_in == WrapVal);
          exp_d    = (RESYNC ? cnt_in : exp_q) + Step;
        end else begin
          mismatch = (cnt_in !== INIT_VAL);
          state_d  = StIdle;
        end
      end
      StHalt: begin
        if (clr) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (mismatch) begin
      err_d = 1'b1;
      if (STOP_ON_ERR) begin
        state_d = StHalt;
      end
    end

    if (clr) begin
      sticky_d   = 1'b0;
      err_cnt_d  = 8'd0;
      wrap_cnt_d = 8'd0;
    end else begin
      if (mismatch) begin
        sticky_d = 1'b1;
        if (err_cnt_q != 8'hFF) begin
          err_cnt_d = err_cnt_q + 8'd1;
        end
      end
      if (wrap) begin
        wrap_cnt_d = wrap_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= StIdle;
      exp_q      <= INIT_VAL;
      err_q      <= 1'b0;
      sticky_q   <= 1'b0;
      err_cnt_q  <= 8'd0;
      wrap_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      exp_q      <= exp_d;
      err_q      <= err_d;
      sticky_q   <= sticky_d;
      err_cnt_q  <= err_cnt_d;
      wrap_cnt_q <= wrap_cnt_d;
    end
  end

  assign err        = err_q;
  assign err_sticky = sticky_q;
  assign err_count  = err_cnt_q;
  assign wrap_count = wrap_cnt_q;
  assign locked     = (state_q == StTrack) && !err_q;
  assign state      = state_q;

endmodule

// File: tb/tb_counter_seq_checker.sv
// Three checkers (plain, resync, stop-on-error) share one stimulus stream; a
// streak-based reference model feeds a scoreboard that a monitor drains each cycle.
module tb_counter_seq_checker;

  localparam logic [3:0] Init = 4'hF;

  typedef struct packed {
    logic       err;
    logic       sticky;
    logic [7:0] ec;
    logic [7:0] wc;
    logic       locked;
    logic [1:0] st;
  } obs_t;
  typedef obs_t [2:0] obs3_t;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       en = 1'b0;
  logic       clr = 1'b0;
  logic [3:0] cnt_in = Init;

  logic       err_w[3];
  logic       sticky_w[3];
  logic       locked_w[3];
  logic [7:0] ec_w[3];
  logic [7:0] wc_w[3];
  logic [1:0] st_w[3];

  int n_checks = 0;
  int n_errs = 0;
  obs3_t sb_q[$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    counter_seq_checker #(
      .WIDTH      (4),
      .INIT_VAL   (4'hF),
      .DIR        (1'b1),
      .RESYNC     (g == 1),
      .STOP_ON_ERR(g == 2)
    ) u_dut (
      .clk       (clk),
      .rstn      (rstn),
      .en        (en),
      .clr       (clr),
      .cnt_in    (cnt_in),
      .err       (err_w[g]),
      .err_sticky(sticky_w[g]),
      .err_count (ec_w[g]),
      .wrap_count(wc_w[g]),
      .locked    (locked_w[g]),
      .state     (st_w[g])
    );
  end

  // Reference model: pos counts position in an enable streak (0 idle, 1 first
  // enabled sample seen, 2 anchored); expected value is anchor minus samples since.
  int         pos[3];
  int         k[3];
  int         ec[3];
  int         wc[3];
  logic [3:0] anchor[3];
  bit         halted[3];
  bit         m_err[3];
  bit         m_sticky[3];

  function automatic void model_reset(int i);
    pos[i] = 0; k[i] = 0; ec[i] = 0; wc[i] = 0; anchor[i] = Init;
    halted[i] = 0; m_err[i] = 0; m_sticky[i] = 0;
  endfunction

  function automatic void model_step(int i);
    bit mm = 0;
    bit wr = 0;
    logic [3:0] want;
    if (halted[i]) begin
      m_err[i] = 0;
      if (clr) begin
        halted[i] = 0; pos[i] = 0; m_sticky[i] = 0; ec[i] = 0; wc[i] = 0;
      end
      return;
    end
    if (pos[i] == 1) begin
      anchor[i] = cnt_in; k[i] = 0; pos[i] = en ? 2 : 0;
    end else if (!en) begin
      mm = (cnt_in !== Init); pos[i] = 0;
    end else if (pos[i] == 0) begin
      pos[i] = 1;
    end else begin
      k[i]++;
      want = anchor[i] - 4'(k[i]);
      mm = (cnt_in !== want);
      wr = !mm && (cnt_in == 4'd0);
      if (mm && i == 1) begin
        anchor[i] = cnt_in; k[i] = 0;
      end
    end
    m_err[i] = mm;
    if (mm && i == 2) halted[i] = 1;
    if (clr) begin
      m_sticky[i] = 0; ec[i] = 0; wc[i] = 0;
    end else begin
      if (mm) begin
        m_sticky[i] = 1;
        if (ec[i] < 255) ec[i]++;
      end
      if (wr) wc[i] = (wc[i] + 1) % 256;
    end
  endfunction

  function automatic obs_t model_obs(int i);
    obs_t o;
    o.err    = m_err[i];
    o.sticky = m_sticky[i];
    o.ec     = 8'(ec[i]);
    o.wc     = 8'(wc[i]);
    o.st     = halted[i] ? 2'd3 : 2'(pos[i]);
    o.locked = !halted[i] && pos[i] == 2 && !m_err[i];
    return o;
  endfunction

  function automatic obs_t get_obs(int i);
    obs_t o;
    o.err = err_w[i]; o.sticky = sticky_w[i]; o.ec = ec_w[i]; o.wc = wc_w[i];
    o.locked = locked_w[i]; o.st = st_w[i];
    return o;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, expv);
    end
  endtask

  task automatic chk_obs(input string nm, input obs_t a, input obs_t e);
    n_checks++;
    if (a !== e) begin
      n_errs++;
      $display("FAIL %s @%0t: got err=%b sticky=%b ec=%0d wc=%0d locked=%b st=%0d, expected err=%b sticky=%b ec=%0d wc=%0d locked=%b st=%0d",
               nm, $time, a.err, a.sticky, a.ec, a.wc, a.locked, a.st,
               e.err, e.sticky, e.ec, e.wc, e.locked, e.st);
    end
  endtask

  initial for (int i = 0; i < 3; i++) model_reset(i);

  always @(posedge clk) begin
    obs3_t e;
    for (int i = 0; i < 3; i++) begin
      if (!rstn) model_reset(i);
      else model_step(i);
      e[i] = model_obs(i);
    end
    sb_q.push_back(e);
  end

  initial begin
    obs3_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() == 0) begin
        n_checks++;
        n_errs++;
        $display("FAIL scoreboard: no expected entry at %0t", $time);
      end else begin
        e = sb_q.pop_front();
        for (int i = 0; i < 3; i++) chk_obs($sformatf("sb_dut%0d", i), get_obs(i), e[i]);
      end
    end
  end

  task automatic cyc(input logic e, input logic c, input logic [3:0] v);
    @(negedge clk);
    en = e; clr = c; cnt_in = v;
  endtask

  initial begin
    logic [3:0] c;
    logic [3:0] v;
    logic       e;
    int         skip;

    // T1: reset then idle with correct value
    repeat (3) cyc(1'b0, 1'b0, Init);
    rstn = 1'b1;
    repeat (5) cyc(1'b0, 1'b0, Init);
    chk("t1_state", 32'(st_w[0]), 32'd0);
    chk("t1_err", 32'(err_w[0]), 32'd0);
    chk("t1_errcnt", 32'(ec_w[0]), 32'd0);

    // T2: one bad idle sample
    cyc(1'b0, 1'b0, 4'hE);
    cyc(1'b0, 1'b0, Init);
    chk("t2_err", 32'(err_w[0]), 32'd1);
    cyc(1'b0, 1'b0, Init);
    chk("t2_err_end", 32'(err_w[0]), 32'd0);
    chk("t2_sticky", 32'(sticky_w[0]), 32'd1);
    chk("t2_errcnt", 32'(ec_w[0]), 32'd1);
    chk("t2_halt", 32'(st_w[2]), 32'd3);
    cyc(1'b0, 1'b1, Init);
    cyc(1'b0, 1'b0, Init);

    // T3: healthy down counter for 40 cycles
    c = Init;
    repeat (40) begin
      cyc(1'b1, 1'b0, c);
      c--;
    end
    cyc(1'b0, 1'b0, Init);
    chk("t3_locked", 32'(locked_w[0]), 32'd1);
    cyc(1'b0, 1'b0, Init);
    chk("t3_wrap", 32'(wc_w[0]), 32'd2);
    chk("t3_errcnt", 32'(ec_w[0]), 32'd0);

    // T4: counter skips one value mid-track
    skip = $urandom_range(4, 12);
    c = Init;
    while (c != 4'(skip)) begin
      cyc(1'b1, 1'b0, c);
      c--;
    end
    c = 4'(skip - 1);
    repeat (6) begin
      cyc(1'b1, 1'b0, c);
      c--;
    end
    cyc(1'b0, 1'b0, Init);
    cyc(1'b0, 1'b0, Init);
    chk("t4_noresync_errcnt", 32'(ec_w[0]), 32'd6);
    chk("t4_resync_errcnt", 32'(ec_w[1]), 32'd1);
    chk("t4_halt", 32'(st_w[2]), 32'd3);

    // T5: halted checker stays frozen until clr
    repeat (10) cyc(1'b0, 1'b0, 4'hE);
    chk("t5_halt", 32'(st_w[2]), 32'd3);
    chk("t5_frozen", 32'(ec_w[2]), 32'd1);
    chk("t5_err_low", 32'(err_w[2]), 32'd0);
    cyc(1'b0, 1'b1, Init);
    cyc(1'b0, 1'b0, Init);
    chk("t5_idle", 32'(st_w[2]), 32'd0);
    chk("t5_clr", 32'(ec_w[2]), 32'd0);

    // Random: enable bursts on a healthy counter with sparse corruption and clears
    c = Init;
    e = 1'b0;
    repeat (300) begin
      if ($urandom_range(0, 7) == 0) e = ~e;
      v = e ? c : Init;
      if ($urandom_range(0, 19) == 0) v = 4'($urandom_range(0, 15));
      cyc(e, 1'($urandom_range(0, 39) == 0), v);
      if (e) c--;
      else c = Init;
    end

    // T6: async reset in the middle of a cycle while tracking
    cyc(1'b0, 1'b1, Init);
    cyc(1'b0, 1'b0, Init);
    c = Init;
    repeat (6) begin
      cyc(1'b1, 1'b0, c);
      c--;
    end
    @(posedge clk);
    #3;
    chk("t6_locked_pre", 32'(locked_w[0]), 32'd1);
    rstn = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) chk_obs($sformatf("t6_rst_dut%0d", i), get_obs(i), '0);
    @(negedge clk);
    en = 1'b0; cnt_in = Init;
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    repeat (300) cyc(1'b0, 1'b0, 4'hE);
    cyc(1'b0, 1'b0, Init);
    chk("t6_saturate", 32'(ec_w[0]), 32'hFF);
    chk("t6_sticky", 32'(sticky_w[0]), 32'd1);
    cyc(1'b0, 1'b0, Init);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
